// File: rtl/otp_fuse_loader_if.sv
// RAM request/response bundle shared by the master-facing and RAM-facing sides
// of the fuse loader.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface otp_fuse_loader_if #(
  parameter int unsigned BUS_WIDTH  = `BUS_WIDTH,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
);
  logic [BUS_WIDTH-1:0]    raddr;
  logic                    ren;
  logic [BUS_WIDTH-1:0]    waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wen;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output raddr, ren, waddr, wdata, wen, input rdata);
  modport slave  (input raddr, ren, waddr, wdata, wen, output rdata);
endinterface

// File: rtl/otp_fuse_loader.sv
// Boot-time OTP fuse shadow loader: copies NUM_WORDS fuse words from RAM into
// shadow registers, then hands the RAM to the master with the fuse window write-protected.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module otp_fuse_loader #(
  parameter int unsigned BUS_WIDTH   = `BUS_WIDTH,
  parameter int unsigned DATA_WIDTH  = `DATA_WIDTH,
  parameter int unsigned NUM_WORDS   = 4,
  parameter int unsigned BASE_ADDR   = 'h10,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  otp_fuse_loader_if.slave                m_ram,
  otp_fuse_loader_if.master               s_ram,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] fuse_data,
  output logic                            load_done,
  output logic                            m_busy,
  output logic                            wr_blocked,
  output logic                            secure_debug_disable
);

  localparam int unsigned         IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned         WCNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [WCNT_W-1:0]   LAST_WCNT = WCNT_W'(RD_LAT - 1);
  localparam logic [BUS_WIDTH-1:0] BASE     = BUS_WIDTH'(BASE_ADDR);
  localparam logic [BUS_WIDTH-1:0] STRIDE   = BUS_WIDTH'(ADDR_STRIDE);
  localparam logic [BUS_WIDTH:0]   WIN_SIZE = (BUS_WIDTH+1)'(NUM_WORDS * ADDR_STRIDE);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [WCNT_W-1:0]     wcnt;
  logic [BUS_WIDTH-1:0]  req_addr;
  logic [BUS_WIDTH-1:0]  win_off;
  logic                  in_window;
  logic                  wr_drop;

  // Offset from BASE keeps the window test correct when the window wraps the address space.
  always_comb begin
    win_off   = m_ram.waddr - BASE;
    in_window = ({1'b0, win_off} < WIN_SIZE);
    wr_drop   = (|m_ram.wen) && (m_busy || in_window);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      wcnt       <= '0;
      req_addr   <= BASE;
      fuse_data  <= '0;
      load_done  <= 1'b0;
      m_busy     <= 1'b1;
      wr_blocked <= 1'b0;
    end else begin
      wr_blocked <= wr_drop;
      unique case (state)
        IDLE: begin
          state    <= REQ;
          idx      <= '0;
          req_addr <= BASE;
        end
        REQ: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          if (wcnt == LAST_WCNT) begin
            fuse_data[idx*DATA_WIDTH +: DATA_WIDTH] <= s_ram.rdata;
            if (idx == LAST_IDX) begin
              state     <= DONE;
              load_done <= 1'b1;
              m_busy    <= 1'b0;
            end else begin
              idx      <= idx + 1'b1;
              req_addr <= req_addr + STRIDE;
              state    <= REQ;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_ram.waddr = m_ram.waddr;
    s_ram.wdata = m_ram.wdata;
    s_ram.wen   = wr_drop ? '0 : m_ram.wen;
    if (state == DONE) begin
      s_ram.raddr = m_ram.raddr;
      s_ram.ren   = m_ram.ren;
      m_ram.rdata = s_ram.rdata;
    end else begin
      s_ram.raddr = req_addr;
      s_ram.ren   = (state == REQ);
      m_ram.rdata = '0;
    end
  end

  always_comb secure_debug_disable = fuse_data[0];

endmodule

// File: doc/otp_fuse_loader.md
OTP_FUSE_LOADER -- requirements
Module: otp_fuse_loader

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter BUS_WIDTH, `BUS_WIDTH, address width.
REQ-003 Parameter DATA_WIDTH, `DATA_WIDTH, data width.
REQ-004 Parameter NUM_WORDS, 4, fuse words shadowed at boot (1..16).
REQ-005 Parameter BASE_ADDR, 'h10, address of fuse word 0.
REQ-006 Parameter ADDR_STRIDE, 4, address increment per word.
REQ-007 Parameter RD_LAT, 1, RAM read latency in cycles (1..4).
REQ-008 Port clk input 1: clock.
REQ-009 Port reset input 1: synchronous active-high reset.
REQ-010 Ports m_ram_raddr, m_ram_ren, m_ram_waddr, m_ram_wdata, m_ram_wen: inputs, BUS_WIDTH/1/BUS_WIDTH/DATA_WIDTH/DATA_WIDTH/8; master request.
REQ-011 Port m_ram_rdata output DATA_WIDTH: read data to master.
REQ-012 Ports s_ram_raddr, s_ram_ren, s_ram_waddr, s_ram_wdata, s_ram_wen: outputs, same widths; RAM request.
REQ-013 Port s_ram_rdata input DATA_WIDTH: RAM read data.
REQ-014 Port fuse_data output NUM_WORDS*DATA_WIDTH: shadowed words, word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 Port load_done output 1: shadow valid, sticky until reset.
REQ-016 Port m_busy output 1: master port blocked (boot load active).
REQ-017 Port wr_blocked output 1: one-cycle pulse when a master write is dropped.
REQ-018 Port secure_debug_disable output 1: fuse_data bit 0.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE; word index idx (0..NUM_WORDS-1), wait counter wcnt (0..RD_LAT-1).
REQ-020 IDLE: one cycle after reset release, then REQ with idx=0.
REQ-021 REQ: one cycle; s_ram_ren=1, s_ram_raddr=BASE_ADDR+idx*ADDR_STRIDE (truncated to BUS_WIDTH, wrap-around allowed); next WAIT, wcnt=0.
REQ-022 WAIT: RD_LAT cycles, s_ram_ren=0; on the clock edge ending the last WAIT cycle, s_ram_rdata is captured into fuse word idx.
REQ-023 After capture: if idx==NUM_WORDS-1 go DONE, else idx+1 and REQ.
REQ-024 DONE: terminal until reset; load_done=1, shadow registers never written again.
REQ-025 Boot load length: load_done rises 1+NUM_WORDS*(RD_LAT+1) cycles after reset deasserts.
REQ-026 m_busy=1 in IDLE/REQ/WAIT, 0 in DONE.
REQ-027 While m_busy: s_ram_wen=0, master reads ignored, m_ram_rdata=0; requests are dropped, not queued.
REQ-028 In DONE: s_ram_raddr=m_ram_raddr, s_ram_ren=m_ram_ren, m_ram_rdata=s_ram_rdata, s_ram_waddr/wdata follow master combinationally.
REQ-029 In DONE: s_ram_wen=m_ram_wen unless m_ram_waddr in [BASE_ADDR, BASE_ADDR+NUM_WORDS*ADDR_STRIDE), then s_ram_wen=0.
REQ-030 wr_blocked registered: 1 in cycle after any nonzero m_ram_wen that was forced to 0 (busy or protected window), else 0.
REQ-031 s_ram_waddr/wdata outputs remain master-driven during load; only s_ram_wen gating matters.

Reset
REQ-032 reset=1 at any edge: state IDLE, idx=0, wcnt=0, fuse_data=0, load_done=0, wr_blocked=0; m_busy=1, s_ram_ren=0, s_ram_wen=0.
REQ-033 Reset mid-load discards partial shadow; full reload restarts after release.

Verification
REQ-034 NUM_WORDS=4, RD_LAT=1, RAM 0x10..0x1C = 1,2,3,4 -> ren pulses at 0x10,0x14,0x18,0x1C, load_done at cycle 9, fuse_data=0x4_3_2_1 per word, secure_debug_disable=1.
REQ-035 RD_LAT=3, NUM_WORDS=2 -> load_done at cycle 9; captured data matches data returned 3 cycles after each REQ.
REQ-036 Master write wen=0xF to 0x14 during load and after DONE -> s_ram_wen=0 both times, wr_blocked pulses twice; write to 0x20 after DONE passes.
REQ-037 Master read 0x40 after DONE -> s_ram_raddr=0x40, m_ram_rdata equals RAM data; same read during load -> m_ram_rdata=0.
REQ-038 Assert reset in WAIT of word 2 -> fuse_data=0, load_done=0; after release, full reload completes in 9 cycles.
REQ-039 Change RAM word 0 after DONE -> fuse_data unchanged.
